// File: rtl/dcsk_rx_pkg.sv
// Types and helpers shared between the DCSK receive demodulator and the TX spreader.
package dcsk_rx_pkg;

    typedef enum logic [2:0] {IDLE, REF, INFO, DECIDE, OUT} demod_state_e;

    // Spread factor is 2^(sel+1), clamped to the largest factor the buffer can hold.
    function automatic logic [4:0] sf_decode(input logic [1:0] sel, input int max_sf);
        int sf;
        sf = 2 << sel;
        if (sf > max_sf) sf = max_sf;
        return 5'(sf);
    endfunction

endpackage

// File: rtl/dcsk_corr_mac.sv
// Reference-chip buffer plus signed multiply-accumulate used to correlate the
// data slot of a DCSK symbol against its stored reference slot.
module dcsk_corr_mac #(
    parameter int SAMPLE_W = 4,
    parameter int MAX_SF   = 16,
    parameter int ACC_W    = 2*SAMPLE_W + $clog2(MAX_SF) + 1,
    parameter int ADDR_W   = $clog2(MAX_SF)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Clear,
    input  logic                    Acc_En,
    input  logic                    Store_En,
    input  logic [ADDR_W-1:0]       Addr,
    input  logic [SAMPLE_W-1:0]     Sample,
    output logic signed [ACC_W-1:0] Acc
);

    logic [SAMPLE_W-1:0] ref_mem [MAX_SF];

    // One-bit samples are hard bits: equal bits correlate to +1, unequal to -1.
    function automatic logic signed [ACC_W-1:0] mac_product(
        input logic [SAMPLE_W-1:0] r,
        input logic [SAMPLE_W-1:0] s
    );
        logic signed [ACC_W-1:0] r_ext;
        logic signed [ACC_W-1:0] s_ext;
        if (SAMPLE_W == 1) begin
            return (r == s) ? ACC_W'(1) : {ACC_W{1'b1}};
        end
        r_ext = {{(ACC_W-SAMPLE_W){r[SAMPLE_W-1]}}, r};
        s_ext = {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
        return r_ext * s_ext;
    endfunction

    always_ff @(posedge Clk) begin
        if (Store_En) begin
            ref_mem[Addr] <= Sample;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Acc <= '0;
        end else if (Clear) begin
            Acc <= '0;
        end else if (Acc_En) begin
            Acc <= Acc + mac_product(ref_mem[Addr], Sample);
        end
    end

endmodule

// File: rtl/dcsk_demod_engine.sv
// Self-sequenced DCSK demodulator: buffers the reference slot, correlates the
// data slot, hard-decides each symbol and packs the bits into a frame word.
module dcsk_demod_engine
    import dcsk_rx_pkg::*;
#(
    parameter int SAMPLE_W   = 4,
    parameter int MAX_SF     = 16,
    parameter int FRAME_BITS = 32
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic [1:0]                      Sf_Sel,
    input  logic                            In_Valid,
    input  logic [SAMPLE_W-1:0]             In_Sample,
    output logic                            In_Ready,
    output logic                            Out_Valid,
    input  logic                            Out_Ready,
    output logic [FRAME_BITS-1:0]           Out_Data,
    output logic [4:0]                      Spread_Factor,
    output logic [$clog2(FRAME_BITS+1)-1:0] Tie_Count
);

    localparam int ACC_W = 2*SAMPLE_W + $clog2(MAX_SF) + 1;
    localparam int CNT_W = $clog2(MAX_SF);
    localparam int BI_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int TC_W  = $clog2(FRAME_BITS+1);

    demod_state_e            state;
    logic [CNT_W-1:0]        cnt;
    logic [BI_W-1:0]         bit_idx;
    logic signed [ACC_W-1:0] acc;
    logic                    hs;
    logic                    last_chip;
    logic                    store_en;
    logic                    acc_en;
    logic                    acc_clr;
    logic [CNT_W-1:0]        mac_addr;

    assign hs        = In_Valid && In_Ready;
    assign last_chip = (5'(cnt) == Spread_Factor - 5'd1);
    assign store_en  = hs && ((state == IDLE) || (state == REF));
    assign acc_en    = hs && (state == INFO);
    assign acc_clr   = (state == DECIDE);
    assign mac_addr  = (state == IDLE) ? '0 : cnt;

    dcsk_corr_mac #(
        .SAMPLE_W (SAMPLE_W),
        .MAX_SF   (MAX_SF),
        .ACC_W    (ACC_W),
        .ADDR_W   (CNT_W)
    ) u_corr_mac (
        .Clk      (Clk),
        .Rst      (Rst),
        .Clear    (acc_clr),
        .Acc_En   (acc_en),
        .Store_En (store_en),
        .Addr     (mac_addr),
        .Sample   (In_Sample),
        .Acc      (acc)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state         <= IDLE;
            In_Ready      <= 1'b0;
            Out_Valid     <= 1'b0;
            Out_Data      <= '0;
            Spread_Factor <= 5'd2;
            Tie_Count     <= '0;
            cnt           <= '0;
            bit_idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    In_Ready <= 1'b1;
                    // The first sample is ref[0]; SF is frozen here for the whole frame.
                    if (hs) begin
                        Spread_Factor <= sf_decode(Sf_Sel, MAX_SF);
                        cnt           <= CNT_W'(1);
                        state         <= REF;
                    end
                end
                REF: begin
                    if (hs) begin
                        if (last_chip) begin
                            cnt   <= '0;
                            state <= INFO;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                INFO: begin
                    if (hs) begin
                        if (last_chip) begin
                            cnt      <= '0;
                            In_Ready <= 1'b0;
                            state    <= DECIDE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DECIDE: begin
                    // Zero correlation decides 0 and is counted as a tie.
                    Out_Data[bit_idx] <= !acc[ACC_W-1] && (acc != '0);
                    if (acc == '0) begin
                        Tie_Count <= Tie_Count + TC_W'(1);
                    end
                    if (bit_idx == BI_W'(FRAME_BITS-1)) begin
                        Out_Valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        bit_idx  <= bit_idx + BI_W'(1);
                        In_Ready <= 1'b1;
                        state    <= REF;
                    end
                end
                OUT: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        Out_Data  <= '0;
                        Tie_Count <= '0;
                        bit_idx   <= '0;
                        In_Ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
